// File: rtl/uart_debug_bridge.sv
// Debug bridge: decodes read/write command frames arriving on a UART byte stream
// into memory accesses, and returns a status byte followed by any read data.
module uart_debug_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned NUM_CORES   = 16,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ID_W-1:0]   mem_id,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int unsigned AB    = ADDR_W / 8;
    localparam int unsigned DB    = DATA_W / 8;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] OP_READ    = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_OP  = 8'hE0;
    localparam logic [7:0] ST_BAD_ID  = 8'hE1;
    localparam logic [7:0] ST_BAD_LEN = 8'hE2;

    typedef enum logic [2:0] {
        IDLE, GET_ID, GET_ADDR, GET_LEN, GET_WDATA, MEM, SEND_STATUS, SEND_RDATA
    } state_t;

    state_t state, state_nxt;

    logic              is_wr, bad_id;
    logic [ID_W-1:0]   id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, rdata_reg;
    logic [7:0]        len_reg, word_cnt, byte_cnt, status_reg, status_val;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              status_ld, err_evt, in_get, tmo, overrun;
    logic              last_word, last_abyte, last_dbyte;

    assign in_get     = (state == GET_ID) || (state == GET_ADDR) ||
                        (state == GET_LEN) || (state == GET_WDATA);
    assign overrun    = rx_valid && ((state == MEM) || (state == SEND_STATUS) ||
                                     (state == SEND_RDATA));
    assign tmo        = in_get && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign last_word  = (word_cnt == len_reg);
    assign last_abyte = (byte_cnt == 8'(AB - 1));
    assign last_dbyte = (byte_cnt == 8'(DB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        status_ld  = 1'b0;
        status_val = ST_OK;
        err_evt    = 1'b0;
        unique case (state)
            IDLE: if (rx_valid) begin
                if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                    state_nxt = GET_ID;
                end else begin
                    state_nxt  = SEND_STATUS;
                    status_ld  = 1'b1;
                    status_val = ST_BAD_OP;
                    err_evt    = 1'b1;
                end
            end
            GET_ID:   if (rx_valid) state_nxt = GET_ADDR;
            GET_ADDR: if (rx_valid && last_abyte) state_nxt = GET_LEN;
            GET_LEN: if (rx_valid) begin
                if ({1'b0, rx_data} >= 9'(MAX_BURST)) begin
                    state_nxt  = SEND_STATUS;
                    status_ld  = 1'b1;
                    status_val = ST_BAD_LEN;
                    err_evt    = 1'b1;
                end else if (is_wr) begin
                    state_nxt = GET_WDATA;
                end else begin
                    state_nxt  = SEND_STATUS;
                    status_ld  = 1'b1;
                    status_val = bad_id ? ST_BAD_ID : ST_OK;
                    err_evt    = bad_id;
                end
            end
            // A bad-id write still drains its data bytes but never touches memory.
            GET_WDATA: if (rx_valid && last_dbyte) begin
                if (!bad_id) begin
                    state_nxt = MEM;
                end else if (last_word) begin
                    state_nxt  = SEND_STATUS;
                    status_ld  = 1'b1;
                    status_val = ST_BAD_ID;
                    err_evt    = 1'b1;
                end
            end
            MEM: if (mem_ack) begin
                if (!is_wr) begin
                    state_nxt = SEND_RDATA;
                end else if (last_word) begin
                    state_nxt  = SEND_STATUS;
                    status_ld  = 1'b1;
                    status_val = ST_OK;
                end else begin
                    state_nxt = GET_WDATA;
                end
            end
            SEND_STATUS: if (tx_ready) state_nxt = (status_reg == ST_OK && !is_wr) ? MEM : IDLE;
            SEND_RDATA:  if (tx_ready && last_dbyte) state_nxt = last_word ? IDLE : MEM;
            default: state_nxt = IDLE;
        endcase
        if (tmo) begin
            state_nxt = IDLE;
            err_evt   = 1'b1;
        end
        if (overrun) err_evt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_wr      <= 1'b0;
            bad_id     <= 1'b0;
            id_reg     <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            len_reg    <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            status_reg <= '0;
            tmo_cnt    <= '0;
            err_count  <= '0;
        end else begin
            if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (status_ld) status_reg <= status_val;
            if (in_get && !rx_valid) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                     tmo_cnt <= '0;
            unique case (state)
                IDLE: if (rx_valid) begin
                    is_wr    <= (rx_data == OP_WRITE);
                    byte_cnt <= '0;
                end
                GET_ID: if (rx_valid) begin
                    id_reg   <= rx_data[ID_W-1:0];
                    bad_id   <= (32'(rx_data) >= NUM_CORES);
                    byte_cnt <= '0;
                end
                GET_ADDR: if (rx_valid) begin
                    for (int unsigned i = 0; i < AB; i++)
                        if (byte_cnt == 8'(i)) addr_reg[i*8 +: 8] <= rx_data;
                    byte_cnt <= last_abyte ? 8'd0 : byte_cnt + 8'd1;
                end
                GET_LEN: if (rx_valid) begin
                    len_reg  <= rx_data;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                end
                GET_WDATA: if (rx_valid) begin
                    for (int unsigned i = 0; i < DB; i++)
                        if (byte_cnt == 8'(i)) wdata_reg[i*8 +: 8] <= rx_data;
                    byte_cnt <= last_dbyte ? 8'd0 : byte_cnt + 8'd1;
                    if (last_dbyte && bad_id) word_cnt <= word_cnt + 8'd1;
                end
                MEM: if (mem_ack) begin
                    addr_reg <= addr_reg + ADDR_W'(DB);
                    byte_cnt <= '0;
                    if (is_wr) word_cnt  <= word_cnt + 8'd1;
                    else       rdata_reg <= mem_rdata;
                end
                SEND_RDATA: if (tx_ready) begin
                    byte_cnt <= last_dbyte ? 8'd0 : byte_cnt + 8'd1;
                    if (last_dbyte) word_cnt <= word_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_req   = (state == MEM);
        mem_we    = (state == MEM) && is_wr;
        mem_id    = id_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        tx_valid  = (state == SEND_STATUS) || (state == SEND_RDATA);
        tx_data   = '0;
        if (state == SEND_STATUS) begin
            tx_data = status_reg;
        end else if (state == SEND_RDATA) begin
            for (int unsigned i = 0; i < DB; i++)
                if (byte_cnt == 8'(i)) tx_data = rdata_reg[i*8 +: 8];
        end
    end
endmodule

// File: tb/tb_uart_debug_bridge.sv
// Directed bench for uart_debug_bridge: frame decode, bursts, error statuses,
// timeout, transmit back-pressure and reset behaviour.
module tb_uart_debug_bridge;
    localparam int unsigned TMO = 40;
    typedef logic [7:0] bq_t[$];

    logic        clk, rst_n;
    logic [7:0]  rx_data, tx_data, err_count;
    logic        rx_valid, tx_valid, tx_ready;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [3:0]  mem_id;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          passed = 0, total = 0, exp_err = 0;
    int unsigned ack_lat = 1, req_seen = 0, stab_err = 0;
    logic [7:0]  tx_log[$];
    logic [31:0] acc_addr[$], acc_wdata[$], rdata_q[$];
    logic        acc_we[$];
    logic [3:0]  acc_id[$];

    uart_debug_bridge #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .NUM_CORES(16),
        .MAX_BURST(16), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_id(mem_id), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks after ack_lat request cycles, logs each access.
    initial begin
        int unsigned req_cyc;
        logic [31:0] a0, w0;
        logic        we0;
        req_cyc = 0; a0 = '0; w0 = '0; we0 = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_seen++;
                req_cyc++;
                if (req_cyc == 1) begin
                    a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
                end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
                    stab_err++;
                end
                if (req_cyc >= ack_lat) begin
                    mem_ack = 1'b1;
                    if (rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
                    else                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
                    acc_addr.push_back(mem_addr);
                    acc_wdata.push_back(mem_wdata);
                    acc_we.push_back(mem_we);
                    acc_id.push_back(mem_id);
                    req_cyc = 0;
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #3;
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic clear();
        tx_log.delete(); acc_addr.delete(); acc_wdata.delete(); acc_we.delete(); acc_id.delete();
        req_seen = 0; stab_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        while ((mem_req || tx_valid) && n < 2000) begin @(negedge clk); n++; end
        if (mem_req || tx_valid) begin
            total++;
            $display("FAIL send_guard got=busy-output exp=quiet before byte %h", b);
        end
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t bytes);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_idle(input int unsigned max_cyc, output bit ok);
        int unsigned n = 0;
        while (busy && n < max_cyc) begin @(negedge clk); n++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem got=%b%b exp=00", mem_req, mem_we); else passed++;
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL reset_tx got=%b/%h exp=0/00", tx_valid, tx_data); else passed++;
        total++; if (err_count !== 8'h00) $display("FAIL reset_err got=%h exp=00", err_count); else passed++;
        total++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_id !== '0) $display("FAIL reset_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_id); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_burst();
        bq_t fr, exp_tx;
        bit ok;
        clear(); ack_lat = 3;
        rdata_q = '{32'h1122_3344, 32'h5566_7788};
        fr = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
        exp_tx = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        send_seq(fr);
        wait_idle(300, ok);
        total++; if (!ok) $display("FAIL read_idle got=busy exp=idle"); else passed++;
        total++; if (tx_log.size() != 9) $display("FAIL read_txlen got=%0d exp=9", tx_log.size()); else passed++;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_tx[i])
                $display("FAIL read_tx[%0d] got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
            else passed++;
        end
        total++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 32'h100 || acc_addr[1] !== 32'h104 || acc_we[0] !== 1'b0 || acc_id[0] !== 4'd2)
            $display("FAIL read_acc got=n%0d a0=%h a1=%h exp=n2 100 104 rd id2", acc_addr.size(), acc_addr[0], acc_addr[1]);
        else passed++;
        total++; if (stab_err != 0) $display("FAIL read_req_stable got=%0d exp=0", stab_err); else passed++;
        total++; if (err_count !== 8'(exp_err)) $display("FAIL read_err got=%0d exp=%0d", err_count, exp_err); else passed++;
    endtask

    task automatic test_write_wrap();
        bq_t fr;
        bit ok;
        clear(); ack_lat = 1;
        fr = '{8'h02, 8'h01, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h01,
               8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00};
        send_seq(fr);
        wait_idle(200, ok);
        total++; if (!ok) $display("FAIL write_idle got=busy exp=idle"); else passed++;
        total++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0)
            $display("FAIL write_addr got=n%0d %h %h exp=n2 fffffffc 00000000", acc_addr.size(), acc_addr[0], acc_addr[1]);
        else passed++;
        total++;
        if (acc_wdata.size() != 2 || acc_wdata[0] !== 32'hA || acc_wdata[1] !== 32'hB || acc_we[0] !== 1'b1 || acc_we[1] !== 1'b1 || acc_id[1] !== 4'd1)
            $display("FAIL write_data got=%h %h exp=0000000a 0000000b we id1", acc_wdata[0], acc_wdata[1]);
        else passed++;
        total++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h00) $display("FAIL write_tx got=n%0d %h exp=n1 00", tx_log.size(), tx_log[0]);
        else passed++;
    endtask

    task automatic test_errors();
        bq_t fr;
        bit ok;
        clear();
        fr = '{8'h7F};
        send_seq(fr); wait_idle(50, ok); exp_err++;
        total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hE0) $display("FAIL bad_op_tx got=n%0d %h exp=E0", tx_log.size(), tx_log[0]); else passed++;
        total++; if (err_count !== 8'(exp_err)) $display("FAIL bad_op_err got=%0d exp=%0d", err_count, exp_err); else passed++;

        clear();
        fr = '{8'h01, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(fr); wait_idle(50, ok); exp_err++;
        total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hE1) $display("FAIL bad_id_rd_tx got=n%0d %h exp=E1", tx_log.size(), tx_log[0]); else passed++;
        total++; if (req_seen != 0) $display("FAIL bad_id_rd_req got=%0d exp=0", req_seen); else passed++;

        clear();
        fr = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        send_seq(fr); wait_idle(50, ok); exp_err++;
        total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hE2) $display("FAIL bad_len_tx got=n%0d %h exp=E2", tx_log.size(), tx_log[0]); else passed++;
        total++; if (req_seen != 0) $display("FAIL bad_len_req got=%0d exp=0", req_seen); else passed++;

        clear();
        fr = '{8'h02, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(fr); wait_idle(50, ok); exp_err++;
        total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hE1) $display("FAIL bad_id_wr_tx got=n%0d %h exp=E1", tx_log.size(), tx_log[0]); else passed++;
        total++; if (req_seen != 0) $display("FAIL bad_id_wr_req got=%0d exp=0", req_seen); else passed++;
        total++; if (err_count !== 8'(exp_err)) $display("FAIL errors_err got=%0d exp=%0d", err_count, exp_err); else passed++;
    endtask

    task automatic test_max_burst();
        bq_t fr;
        bit ok;
        clear(); ack_lat = 1;
        fr = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h0F};
        send_seq(fr); wait_idle(600, ok);
        total++; if (!ok || acc_addr.size() != 16) $display("FAIL max_burst_n got=%0d exp=16", acc_addr.size()); else passed++;
        total++; if (acc_addr.size() != 16 || acc_addr[15] !== 32'h23C) $display("FAIL max_burst_last got=%h exp=0000023c", acc_addr[15]); else passed++;
        total++;
        if (tx_log.size() != 65 || tx_log[0] !== 8'h00 || tx_log[61] !== 8'h3C || tx_log[64] !== 8'hA5)
            $display("FAIL max_burst_tx got=n%0d %h %h %h exp=n65 00 3c a5", tx_log.size(), tx_log[0], tx_log[61], tx_log[64]);
        else passed++;
    endtask

    task automatic test_timeout();
        bq_t fr;
        bit ok;
        clear();
        fr = '{8'h02, 8'h03, 8'h00, 8'h00};
        send_seq(fr);
        repeat (TMO - 1) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL timeout_early got=busy%b exp=busy1", busy); else passed++;
        @(negedge clk);
        exp_err++;
        total++; if (busy !== 1'b0) $display("FAIL timeout_fire got=busy%b exp=busy0", busy); else passed++;
        total++; if (err_count !== 8'(exp_err)) $display("FAIL timeout_err got=%0d exp=%0d", err_count, exp_err); else passed++;
        total++; if (tx_log.size() != 0) $display("FAIL timeout_tx got=n%0d exp=n0", tx_log.size()); else passed++;

        clear();
        fr = '{8'h02, 8'h03, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(fr); wait_idle(100, ok);
        total++;
        if (acc_addr.size() != 1 || acc_addr[0] !== 32'h20 || acc_wdata[0] !== 32'hDEAD_BEEF || acc_id[0] !== 4'd3)
            $display("FAIL after_timeout_acc got=n%0d %h %h exp=n1 00000020 deadbeef", acc_addr.size(), acc_addr[0], acc_wdata[0]);
        else passed++;
        total++; if (tx_log.size() != 1 || tx_log[0] !== 8'h00) $display("FAIL after_timeout_tx got=n%0d %h exp=00", tx_log.size(), tx_log[0]); else passed++;
    endtask

    task automatic test_tx_stall();
        bq_t fr, exp_tx;
        bit ok;
        int unsigned n, bad;
        logic [7:0] held;
        clear(); ack_lat = 2;
        rdata_q = '{32'hCAFE_F00D};
        exp_tx = '{8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        tx_ready = 1'b0;
        fr = '{8'h01, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(fr);
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        held = tx_data;
        total++; if (!tx_valid || held !== 8'h0D) $display("FAIL stall_first got=%b/%h exp=1/0d", tx_valid, held); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin rx_data = 8'h55; rx_valid = 1'b1; end
            else rx_valid = 1'b0;
            @(negedge clk);
            if (!tx_valid || tx_data !== held) bad++;
        end
        rx_valid = 1'b0;
        exp_err++;
        total++; if (bad != 0) $display("FAIL stall_stable got=%0d exp=0", bad); else passed++;
        tx_ready = 1'b1;
        wait_idle(100, ok);
        total++; if (tx_log.size() != 5) $display("FAIL stall_txlen got=%0d exp=5", tx_log.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_tx[i])
                $display("FAIL stall_tx[%0d] got=%h exp=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
            else passed++;
        end
        total++; if (err_count !== 8'(exp_err)) $display("FAIL overrun_err got=%0d exp=%0d", err_count, exp_err); else passed++;
    endtask

    task automatic test_reset_mid_access();
        bq_t fr;
        int unsigned n;
        clear(); ack_lat = 1000;
        fr = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(fr);
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        total++; if (mem_req !== 1'b1) $display("FAIL midrst_reach got=%b exp=1", mem_req); else passed++;
        total++; if (err_count !== 8'(exp_err)) $display("FAIL midrst_pre_err got=%0d exp=%0d", err_count, exp_err); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        exp_err = 0;
        total++; if (mem_req !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL midrst_out got=%b%b%b exp=000", mem_req, busy, tx_valid); else passed++;
        total++; if (err_count !== 8'h00) $display("FAIL midrst_err got=%0d exp=0", err_count); else passed++;
        rst_n = 1'b1;
        req_seen = 0; tx_log.delete();
        repeat (10) @(negedge clk);
        total++; if (req_seen != 0 || tx_log.size() != 0) $display("FAIL midrst_quiet got=req%0d tx%0d exp=0 0", req_seen, tx_log.size()); else passed++;
        ack_lat = 1;
    endtask

    task automatic test_saturate();
        bit ok;
        clear();
        for (int i = 0; i < 260; i++) send_byte(8'h7F);
        wait_idle(50, ok);
        total++; if (err_count !== 8'hFF) $display("FAIL saturate_err got=%0d exp=255", err_count); else passed++;
        total++; if (tx_log.size() != 260 || tx_log[259] !== 8'hE0) $display("FAIL saturate_tx got=n%0d exp=n260 E0", tx_log.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_wrap();
        test_errors();
        test_max_burst();
        test_timeout();
        test_tx_stall();
        test_reset_mid_access();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_debug_bridge.md
UART_DEBUG_BRIDGE -- requirements
Module: uart_debug_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_W, default 32, memory data width in bits (multiple of 8).
REQ-003 SHALL have parameter ID_W, default 4, core-select width; NUM_CORES, default 16, number of valid ids.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum words per command (1..256); TIMEOUT_CYC, default 100000, inter-byte timeout in clocks.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 rx_data  in  8  received byte; rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-008 tx_data  out  8  byte to transmit; tx_valid  out  1; tx_ready  in  1; byte transfers when tx_valid && tx_ready.
REQ-009 mem_req  out  1; mem_we  out  1; mem_id  out  ID_W; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W.
REQ-010 mem_ack  in  1  access completes when mem_req && mem_ack; mem_rdata  in  DATA_W  valid in the ack cycle.
REQ-011 busy  out  1  high in every state except IDLE; err_count  out  8  saturating error counter.

Function
REQ-012 Frame SHALL be: opcode, id byte (low ID_W bits used), AB=ADDR_W/8 address bytes LSB-first, len byte (words = len+1), then for writes (len+1)*DB data bytes LSB-first, DB=DATA_W/8.
REQ-013 Opcodes SHALL be 0x01 READ, 0x02 WRITE; any other opcode -> status 0xE0, err_count++, return IDLE.
REQ-014 States SHALL be IDLE, GET_ID, GET_ADDR, GET_LEN, GET_WDATA, MEM, SEND_STATUS, SEND_RDATA.
REQ-015 IDLE -> GET_ID on rx_valid with valid opcode; GET_ID -> GET_ADDR; GET_ADDR -> GET_LEN after AB bytes.
REQ-016 GET_LEN: len+1 > MAX_BURST -> status 0xE2, err_count++, IDLE; READ -> SEND_STATUS(0x00) -> MEM; WRITE -> GET_WDATA.
REQ-017 id >= NUM_CORES SHALL set a bad-id flag; frame fully consumed, no mem_req issued, final status 0xE1, err_count++.
REQ-018 GET_WDATA -> MEM after DB bytes; WRITE MEM -> GET_WDATA until all words done, then SEND_STATUS 0x00 (or 0xE1).
REQ-019 READ MEM -> SEND_RDATA on ack; SEND_RDATA sends DB bytes LSB-first of captured mem_rdata, then MEM for next word or IDLE.
REQ-020 mem_req SHALL assert on MEM entry, hold with mem_we/id/addr/wdata stable until ack cycle, deassert the cycle after ack.
REQ-021 mem_ack while mem_req low SHALL be ignored; ack in the first req cycle SHALL be accepted (min 1 cycle per access).
REQ-022 mem_addr SHALL increment by DB per word, modulo 2^ADDR_W (wrap to 0).
REQ-023 tx_valid SHALL only assert in SEND_STATUS/SEND_RDATA; tx_data stable while tx_valid && !tx_ready; next byte presented the cycle after transfer, no bubble required.
REQ-024 rx_valid in MEM/SEND_STATUS/SEND_RDATA SHALL drop the byte and increment err_count (overrun).
REQ-025 In GET_* states, TIMEOUT_CYC cycles without rx_valid SHALL abort to IDLE, err_count++, no status sent; rx_valid in the expiry cycle wins.
REQ-026 err_count SHALL saturate at 255; multiple error events in one cycle count once.
REQ-027 Status SHALL be one byte preceding read data (READ) or the only response byte (WRITE).

Reset
REQ-028 rst_n low at a clock edge SHALL force IDLE, mem_req=0, mem_we=0, tx_valid=0, busy=0, err_count=0, mem_addr/mem_id/mem_wdata/tx_data=0.
REQ-029 Reset mid-frame or mid-access SHALL abandon the command; no further mem_req or tx_valid until a new frame.

Verification
REQ-030 READ id=2 addr=0x00000100 len=1, ack after 3 cycles, rdata 0x11223344/0x55667788 -> tx 00 44 33 22 11 88 77 66 55; addrs 0x100, 0x104.
REQ-031 WRITE id=1 addr=0xFFFFFFFC len=1 data 0xA,0xB -> writes 0xFFFFFFFC then 0x00000000; tx 00.
REQ-032 Opcode 0x7F -> tx E0, err_count=1; READ id=20 -> tx E1, no mem_req; len=16 -> tx E2.
REQ-033 Frame stalls after 2 address bytes for TIMEOUT_CYC cycles -> IDLE, no tx, err_count+1; next valid frame served.
REQ-034 tx_ready held low 10 cycles during SEND_RDATA -> tx_data stable, no byte lost; rx byte during send -> err_count+1.
REQ-035 rst_n low while mem_req high -> next cycle mem_req=0, busy=0, err_count=0.
